// File: rtl/mac8_dot_seq_if.sv
// mac8_dot_seq_if: command, operand, FU and result ports for the
// mac8 dot-product sequencer. "slave" is the sequencer's view and
// "master" is the view of the surrounding source/FU/consumer.
interface mac8_dot_seq_if #(
  parameter int LEN_W = 8
);
  // command port
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [LEN_W-1:0] cmd_len_i;
  logic             cmd_acc_i;
  // operand stream
  logic             op_valid_i;
  logic             op_ready_o;
  logic [31:0]      op_a_i;
  logic [31:0]      op_b_i;
  // mac8 functional unit
  logic [31:0]      mac_a_o;
  logic [31:0]      mac_b_o;
  logic             mac_valid_o;
  logic [31:0]      mac_res_i;
  // result port and status
  logic             res_valid_o;
  logic             res_ready_i;
  logic [31:0]      res_o;
  logic             res_ovf_o;
  logic             busy_o;

  modport slave (
    input  cmd_valid_i, cmd_len_i, cmd_acc_i,
    input  op_valid_i, op_a_i, op_b_i,
    input  mac_res_i, res_ready_i,
    output cmd_ready_o, op_ready_o,
    output mac_a_o, mac_b_o, mac_valid_o,
    output res_valid_o, res_o, res_ovf_o, busy_o
  );

  modport master (
    output cmd_valid_i, cmd_len_i, cmd_acc_i,
    output op_valid_i, op_a_i, op_b_i,
    output mac_res_i, res_ready_i,
    input  cmd_ready_o, op_ready_o,
    input  mac_a_o, mac_b_o, mac_valid_o,
    input  res_valid_o, res_o, res_ovf_o, busy_o
  );
endinterface

// File: rtl/mac8_dot_seq.sv
// mac8_dot_seq: streams N operand-word pairs through the combinational
// mac8 FU, one pair per cycle, and accumulates the 32-bit partial sums
// into a signed 32-bit accumulator returned over a valid/ready port.
// Optional feature macro: MAC8_DOT_SEQ_SAT_EN -- when defined the
// accumulator saturates on signed overflow instead of wrapping.
module mac8_dot_seq #(
  parameter int LEN_W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  mac8_dot_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;

  // Handshake flags are registered copies of the next state so that
  // they never combinationally depend on inputs.
  logic cmd_ready_q, op_ready_q, res_valid_q, busy_q;

  logic [31:0] add_sum;
  logic        beat_ovf;
  logic [31:0] beat_acc;

  // Accumulator update for one beat: two's-complement add, overflow
  // when both addends share a sign that the sum does not.
  always_comb begin
    add_sum  = acc_q + bus.mac_res_i;
    beat_ovf = (acc_q[31] == bus.mac_res_i[31]) && (add_sum[31] != acc_q[31]);
`ifdef MAC8_DOT_SEQ_SAT_EN
    if (beat_ovf) begin
      // a negative accumulator can only overflow downwards
      beat_acc = acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      beat_acc = add_sum;
    end
`else
    beat_acc = add_sum;
`endif
  end

  // Next-state logic; flush wins over any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid_i) begin
            cnt_d = bus.cmd_len_i;
            if (!bus.cmd_acc_i) begin
              acc_d = '0;
              ovf_d = 1'b0;
            end
            state_d = (bus.cmd_len_i != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (bus.op_valid_i) begin
            acc_d = beat_acc;
            ovf_d = ovf_q | beat_ovf;
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.res_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered handshake flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      op_ready_q  <= (state_d == ST_RUN);
      res_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Operands pass straight to the FU only while a beat can be taken.
  always_comb begin
    bus.mac_a_o     = op_ready_q ? bus.op_a_i : 32'h0;
    bus.mac_b_o     = op_ready_q ? bus.op_b_i : 32'h0;
    bus.mac_valid_o = op_ready_q & bus.op_valid_i;
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.op_ready_o  = op_ready_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_o       = acc_q;
  assign bus.res_ovf_o   = ovf_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mac8_dot_seq.sv
// tb_mac8_dot_seq: directed stimulus with a result scoreboard. The
// stimulus process pushes hand-computed results; a monitor pops and
// compares on every result handshake.
module tb_mac8_dot_seq;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;

  mac8_dot_seq_if #(.LEN_W(8)) bus ();

  mac8_dot_seq #(.LEN_W(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  // mac8 FU: sum of four signed(a byte) * unsigned(b byte), or a stub.
  logic        stub_en;
  logic [31:0] stub_val;

  function automatic logic [31:0] fu_dot(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      s += int'($signed(a[8*i +: 8])) * int'({1'b0, b[8*i +: 8]});
    end
    return s;
  endfunction

  assign bus.mac_res_i = stub_en ? stub_val : fu_dot(bus.mac_a_o, bus.mac_b_o);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: every accepted result is compared with the oldest entry.
  always @(negedge clk_i) begin
    if (!rst_i && bus.res_valid_o && bus.res_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_o", bus.res_o, e.res);
        check("res_ovf_o", {31'd0, bus.res_ovf_o}, {31'd0, e.ovf});
        $display("result res=0x%08h ovf=%0d (exp 0x%08h/%0d)", bus.res_o, bus.res_ovf_o, e.res, e.ovf);
      end
    end
  end

  task automatic send_cmd(input logic [7:0] len, input logic acc);
    bus.cmd_len_i   = len;
    bus.cmd_acc_i   = acc;
    bus.cmd_valid_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 20 && !bus.cmd_ready_o; i++) @(negedge clk_i);
    if (!bus.cmd_ready_o) check("cmd_timeout", 32'd1, 32'd0);
    @(posedge clk_i);
    #1 bus.cmd_valid_i = 1'b0;
    $display("cmd len=%0d acc=%0d", len, acc);
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    bus.op_a_i     = a;
    bus.op_b_i     = b;
    bus.op_valid_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 20 && !bus.op_ready_o; i++) @(negedge clk_i);
    if (!bus.op_ready_o) check("beat_timeout", 32'd1, 32'd0);
    check("mac_a_o", bus.mac_a_o, a);
    check("mac_valid_o", {31'd0, bus.mac_valid_o}, 32'd1);
    @(posedge clk_i);
    #1 bus.op_valid_i = 1'b0;
    $display("beat a=0x%08h b=0x%08h", a, b);
  endtask

  task automatic push_exp(input logic [31:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready_o}, 32'd1);
    check({tag, "_op_ready"}, {31'd0, bus.op_ready_o}, 32'd0);
    check({tag, "_res_valid"}, {31'd0, bus.res_valid_o}, 32'd0);
    check({tag, "_res_o"}, bus.res_o, 32'd0);
    check({tag, "_res_ovf"}, {31'd0, bus.res_ovf_o}, 32'd0);
    check({tag, "_mac_a"}, bus.mac_a_o, 32'd0);
    check({tag, "_mac_valid"}, {31'd0, bus.mac_valid_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; stub_en = 1'b0; stub_val = 32'h0;
    bus.cmd_valid_i = 1'b0; bus.cmd_len_i = '0; bus.cmd_acc_i = 1'b0;
    bus.op_valid_i = 1'b0; bus.op_a_i = 32'h0; bus.op_b_i = 32'h0;
    bus.res_ready_i = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // single beat: 4 * (1*2) = 8, result one cycle after the beat
    push_exp(32'h0000_0008, 1'b0);
    send_cmd(8'd1, 1'b0);
    send_beat(32'h0101_0101, 32'h0202_0202);
    @(negedge clk_i);
    check("t1_res_valid_lat", {31'd0, bus.res_valid_o}, 32'd1);
    @(posedge clk_i); #1;

    // three beats of -1020, gapped by idle cycles: -3060
    push_exp(32'hFFFF_F40C, 1'b0);
    send_cmd(8'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      if (k < 2) begin
        @(negedge clk_i);
        check("t2_gap_mac_valid", {31'd0, bus.mac_valid_o}, 32'd0);
        check("t2_gap_res_valid", {31'd0, bus.res_valid_o}, 32'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
      end
    end
    @(negedge clk_i);
    check("t2_res_valid_lat", {31'd0, bus.res_valid_o}, 32'd1);
    @(posedge clk_i); #1;

    // 0x10, then continue with zero beats, then restart from zero
    push_exp(32'h0000_0010, 1'b0);
    send_cmd(8'd2, 1'b0);
    send_beat(32'h0101_0101, 32'h0202_0202);
    send_beat(32'h0101_0101, 32'h0202_0202);
    @(negedge clk_i); @(posedge clk_i); #1;
    push_exp(32'h0000_0010, 1'b0);
    send_cmd(8'd0, 1'b1);
    @(negedge clk_i);
    check("t3_zero_len_lat", {31'd0, bus.res_valid_o}, 32'd1);
    @(posedge clk_i); #1;
    push_exp(32'h0000_0000, 1'b0);
    send_cmd(8'd0, 1'b0);
    @(negedge clk_i); @(posedge clk_i); #1;

    // overflow with stub FU: 0x40000000 + 0x40000000
    stub_en = 1'b1; stub_val = 32'h4000_0000;
`ifdef MAC8_DOT_SEQ_SAT_EN
    push_exp(32'h7FFF_FFFF, 1'b1);
`else
    push_exp(32'h8000_0000, 1'b1);
`endif
    send_cmd(8'd2, 1'b0);
    send_beat(32'h0, 32'h0);
    send_beat(32'h0, 32'h0);
    @(negedge clk_i); @(posedge clk_i); #1;
    stub_en = 1'b0;

    // flush during the third of five beats
    send_cmd(8'd5, 1'b0);
    send_beat(32'h0101_0101, 32'h0202_0202);
    send_beat(32'h0101_0101, 32'h0202_0202);
    bus.op_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    bus.op_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_busy", {31'd0, bus.busy_o}, 32'd0);
    check("flush_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    push_exp(32'h0000_0000, 1'b0);
    send_cmd(8'd0, 1'b1);
    @(negedge clk_i); @(posedge clk_i); #1;

    // result held while the consumer stalls
    bus.res_ready_i = 1'b0;
    push_exp(32'h0000_0008, 1'b0);
    send_cmd(8'd1, 1'b0);
    send_beat(32'h0101_0101, 32'h0202_0202);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("hold_res_valid", {31'd0, bus.res_valid_o}, 32'd1);
      check("hold_res_o", bus.res_o, 32'h0000_0008);
      check("hold_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    bus.res_ready_i = 1'b1;
    @(negedge clk_i); @(posedge clk_i); #1;

    // asynchronous reset in the middle of a command
    send_cmd(8'd3, 1'b0);
    send_beat(32'h0101_0101, 32'h0202_0202);
    bus.op_valid_i = 1'b1;
    #2 rst_i = 1'b1;
    #1 check_reset_outputs("midrun_rst");
    bus.op_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mac8_dot_seq.md
# mac8_dot_seq

Dot-product sequencer for the packed 8-bit MAC functional unit. Accepts a command of N operand-word pairs and streams them through the combinational mac8 FU at one pair per cycle. Accumulates the per-word 32-bit partial sums into a running 32-bit signed accumulator and returns the final sum through a valid/ready result port. Sits between a load/stream source and the mac8 FU, so long int8×uint8 dot products need no per-word instruction issue.

## Interface
- LEN_W, 8, width of the beat-count field; maximum command length is 2^LEN_W−1 beats
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous abort, returns to IDLE
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_len_i  in  LEN_W  number of operand beats (0 allowed)
- cmd_acc_i  in  1  1: continue from current accumulator; 0: start from zero
- op_valid_i  in  1  operand pair offered
- op_ready_o  out  1  operand pair accepted when high with op_valid_i
- op_a_i  in  32  four packed signed bytes
- op_b_i  in  32  four packed unsigned bytes
- mac_a_o  out  32  operand A to mac8 FU
- mac_b_o  out  32  operand B to mac8 FU
- mac_valid_o  out  1  FU operands meaningful this cycle
- mac_res_i  in  32  FU result, combinational, same cycle
- res_valid_o  out  1  final result available
- res_ready_i  in  1  result consumed when high with res_valid_o
- res_o  out  32  accumulated signed sum
- res_ovf_o  out  1  sticky signed-overflow flag for this result
- busy_o  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cmd_ready_o=1. On cmd_valid_i: cnt←cmd_len_i. If cmd_acc_i=0, then acc←0 and ovf←0; if cmd_acc_i=1, acc and ovf are held. Next state is RUN if cmd_len_i≠0, else DONE.
- RUN: op_ready_o=1. mac_a_o=op_a_i, mac_b_o=op_b_i, mac_valid_o=op_valid_i.
  - On each accepted beat: acc←acc+mac_res_i (32-bit two's complement), cnt←cnt−1.
  - ovf sets when both addends have the same sign and the sum's sign differs.
  - The beat taken with cnt==1 moves the block to DONE.
  - Cycles without op_valid_i leave all state unchanged.
- DONE: res_valid_o=1, res_o=acc, res_ovf_o=ovf. On res_ready_i, go to IDLE. acc and ovf are retained for a following cmd_acc_i=1 command.
- Outside RUN: mac_a_o=mac_b_o=0, mac_valid_o=0, op_ready_o=0.
- Outside IDLE: cmd_ready_o=0.
- Outside DONE: res_valid_o=0.
- flush_i, any state: go to IDLE next cycle with acc=0, ovf=0, cnt=0. flush_i has priority over any same-cycle handshake, and a beat or command presented in that cycle is dropped.

## Timing
- Reset values: state=IDLE, acc=0, ovf=0, cnt=0.
- Output values at reset: cmd_ready_o=1, op_ready_o=0, res_valid_o=0, res_o=0, res_ovf_o=0, mac_*_o=0, mac_valid_o=0, busy_o=0.
- Latency:
  - Command accept → RUN: 1 cycle.
  - Last beat accepted → res_valid_o: 1 cycle.
  - Zero-length command → res_valid_o: 1 cycle after accept.
- Throughput: 1 beat/cycle in RUN. An N-beat command takes N+2 cycles minimum from cmd accept to res_valid_o deassert, with res_ready_i held high.
- res_o and res_ovf_o are registered, stable while res_valid_o=1, and change only after a handshake, flush, or reset.
- cmd_ready_o, op_ready_o and res_valid_o depend only on state (no combinational path from inputs).
- Reset asserted mid-command: immediate asynchronous return to reset values; the in-flight command is lost.

## Configuration
- MAC8_DOT_SEQ_SAT_EN defined: on overflow, acc clamps to 0x7FFFFFFF (positive overflow) or 0x80000000 (negative overflow), and ovf still sets. Later beats add to the clamped value.
- Not defined: acc wraps modulo 2^32, and ovf still sets and stays sticky.

## Test plan
- Real mac8 FU attached, cmd_len=1, cmd_acc=0, a=0x01010101, b=0x02020202 -> res_o=0x00000008, res_ovf_o=0, res_valid_o 1 cycle after beat.
- Real FU, cmd_len=3, each beat a=0xFFFFFFFF, b=0xFFFFFFFF (−1020 per beat), op_valid_i gapped by 2 idle cycles -> res_o=0xFFFFF40C after third beat; no accumulation on idle cycles.
- cmd_len=2 result 0x10, then cmd_acc=1 with cmd_len=0 -> DONE 1 cycle after accept with res_o=0x10. Then cmd_acc=0, cmd_len=0 -> res_o=0.
- Stub FU driving mac_res_i=0x40000000, cmd_len=2 -> with macro: res_o=0x7FFFFFFF, res_ovf_o=1; without macro: res_o=0x80000000, res_ovf_o=1.
- cmd_len=5, flush_i asserted after 2 beats, same cycle as a valid beat -> that beat dropped, IDLE next cycle, busy_o=0, then a cmd_acc=1, cmd_len=0 command returns res_o=0.
- res_ready_i held low 4 cycles in DONE -> res_valid_o and res_o stable, cmd_ready_o=0 throughout. rst_i pulsed mid-RUN -> all outputs at reset values within the same cycle.
